// File: rtl/quad_encoder_frontend.sv
// Rotary-encoder front end: synchronises and debounces A/B/button, decodes
// quadrature into per-detent step pulses, and toggles a mode flag on each press.
module quad_encoder_frontend #(
  parameter logic [15:0] DEBOUNCE_CYCLES  = 16'd50000,
  parameter int          CNT_W            = 16,
  parameter logic [2:0]  STEPS_PER_DETENT = 3'd4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic rawA,
  input  logic rawB,
  input  logic rawbtn,
  output logic encA,
  output logic encB,
  output logic step_up,
  output logic step_dn,
  output logic mode,
  output logic err
);

  localparam int                NPIN     = 3;
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 16'd1);
  localparam logic signed [3:0] STEP_POS = $signed({1'b0, STEPS_PER_DETENT});
  localparam logic signed [3:0] STEP_NEG = -STEP_POS;

  typedef enum logic [1:0] {
    MOVE_NONE,
    MOVE_FWD,
    MOVE_REV,
    MOVE_ILLEGAL
  } move_e;

  // Pin order inside the per-pin vectors: 0 = A, 1 = B, 2 = button.
  logic [NPIN-1:0]   raw_w;
  logic [NPIN-1:0]   sync1_q, sync2_q;
  logic [NPIN-1:0]   stable_q, stable_d;
  logic [CNT_W-1:0]  cnt_q [NPIN];
  logic [CNT_W-1:0]  cnt_d [NPIN];

  logic [1:0]        cur_w, prev_q;
  move_e             move;
  logic signed [3:0] sub_q, sub_d, sub_sum;
  logic              step_up_q, step_up_d;
  logic              step_dn_q, step_dn_d;
  logic              btn_prev_q, mode_q, mode_d;

  assign raw_w = {rawbtn, rawB, rawA};
  assign cur_w = {stable_q[0], stable_q[1]};

  // NOTE: default every combinational output before any branch so no path
  // leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NPIN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) stable_d[i] = sync2_q[i];
        else                     cnt_d[i]    = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    move = MOVE_NONE;
    case ({prev_q, cur_w})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: move = MOVE_FWD;
      4'b0010, 4'b1011, 4'b1101, 4'b0100: move = MOVE_REV;
      4'b0011, 4'b1100, 4'b0110, 4'b1001: move = MOVE_ILLEGAL;
      default:                            move = MOVE_NONE;
    endcase
  end

  always_comb begin
    sub_sum   = sub_q;
    sub_d     = sub_q;
    step_up_d = 1'b0;
    step_dn_d = 1'b0;
    if (move == MOVE_FWD)      sub_sum = sub_q + 4'sd1;
    else if (move == MOVE_REV) sub_sum = sub_q - 4'sd1;

    // A disabled decoder or a skipped quadrature state discards the partial detent.
    if (!en || move == MOVE_ILLEGAL) begin
      sub_d = '0;
    end else if (sub_sum == STEP_POS) begin
      step_up_d = 1'b1;
      sub_d     = '0;
    end else if (sub_sum == STEP_NEG) begin
      step_dn_d = 1'b1;
      sub_d     = '0;
    end else begin
      sub_d = sub_sum;
    end
  end

  assign mode_d = mode_q ^ (stable_q[2] & ~btn_prev_q);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      stable_q   <= '0;
      // NOTE: the counter array is a handful of flops, not a RAM, so it is
      // cleared element by element along with everything else.
      for (int i = 0; i < NPIN; i++) cnt_q[i] <= '0;
      prev_q     <= '0;
      sub_q      <= '0;
      step_up_q  <= 1'b0;
      step_dn_q  <= 1'b0;
      btn_prev_q <= 1'b0;
      mode_q     <= 1'b0;
    end else begin
      sync1_q    <= raw_w;
      sync2_q    <= sync1_q;
      stable_q   <= stable_d;
      for (int i = 0; i < NPIN; i++) cnt_q[i] <= cnt_d[i];
      prev_q     <= cur_w;
      sub_q      <= sub_d;
      step_up_q  <= step_up_d;
      step_dn_q  <= step_dn_d;
      btn_prev_q <= stable_q[2];
      mode_q     <= mode_d;
    end
  end

  assign encA    = stable_q[0];
  assign encB    = stable_q[1];
  assign step_up = step_up_q;
  assign step_dn = step_dn_q;
  assign mode    = mode_q;
  // err is decoded directly from cur/prev, so it is visible in the same
  // cycle the illegal debounced change appears.
  assign err     = en && (move == MOVE_ILLEGAL);

endmodule

// File: tb/tb_quad_encoder_frontend.sv
// Directed bench for quad_encoder_frontend with DEBOUNCE_CYCLES=8 and
// STEPS_PER_DETENT=4; expected values are hand-derived cycle counts.
module tb_quad_encoder_frontend;

  logic clk;
  logic reset;
  logic en;
  logic rawA, rawB, rawbtn;
  logic encA, encB, step_up, step_dn, mode, err;

  int checks   = 0;
  int failures = 0;

  // Pulse / activity counters maintained by the monitor; steps snapshot them.
  int n_up = 0, n_dn = 0, n_err = 0, n_ahi = 0, n_viol = 0;
  int s_up, s_dn, s_err, s_ahi;
  logic prev_any = 1'b0;

  quad_encoder_frontend #(
    .DEBOUNCE_CYCLES (16'd8),
    .CNT_W           (16),
    .STEPS_PER_DETENT(3'd4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .rawA   (rawA),
    .rawB   (rawB),
    .rawbtn (rawbtn),
    .encA   (encA),
    .encB   (encB),
    .step_up(step_up),
    .step_dn(step_dn),
    .mode   (mode),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    logic any;
    any = step_up | step_dn | err;
    if (step_up === 1'b1) n_up++;
    if (step_dn === 1'b1) n_dn++;
    if (err === 1'b1)     n_err++;
    if (encA === 1'b1)    n_ahi++;
    if ((int'(step_up) + int'(step_dn) + int'(err)) > 1 || (any && prev_any)) n_viol++;
    prev_any = any;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Leaves the bench 1 time unit after the n-th rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a, input logic b, input int hold);
    rawA = a;
    rawB = b;
    tick(hold);
  endtask

  task automatic snap();
    s_up  = n_up;
    s_dn  = n_dn;
    s_err = n_err;
    s_ahi = n_ahi;
  endtask

  initial begin
    reset  = 1'b0;
    en     = 1'b1;
    rawA   = 1'b0;
    rawB   = 1'b0;
    rawbtn = 1'b0;
    tick(3);
    check("reset_outputs", {encA, encB, step_up, step_dn, mode, err}, 6'b0);
    reset = 1'b1;
    tick(5);

    // 1. Reset mid-rotation with subcount=2 and mode=1.
    rawbtn = 1'b1;
    tick(20);
    check("t1_mode_set", mode, 1'b1);
    rawbtn = 1'b0;
    tick(20);
    check("t1_release_no_toggle", mode, 1'b1);
    snap();
    drive(1'b0, 1'b1, 20);
    drive(1'b1, 1'b1, 20);
    check("t1_pre_reset_enc", {encA, encB}, 2'b11);
    check("t1_pre_reset_no_step", n_up - s_up, 0);
    #3;
    reset = 1'b0;
    #1;
    check("t1_async_clear", {encA, encB, step_up, step_dn, mode, err}, 6'b0);
    rawA = 1'b0;
    rawB = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(5);
    snap();
    drive(1'b0, 1'b1, 20);
    drive(1'b1, 1'b1, 20);
    drive(1'b1, 1'b0, 20);
    check("t1_no_step_after_3", n_up - s_up, 0);
    drive(1'b0, 1'b0, 20);
    check("t1_one_step_up", n_up - s_up, 1);
    check("t1_no_err", n_err - s_err, 0);

    // 2. Bounce on rawA shorter than the debounce window.
    snap();
    for (int i = 0; i < 10; i++) begin
      rawA = ~rawA;
      tick(3);
    end
    rawA = 1'b0;
    tick(20);
    check("t2_encA_never_high", n_ahi - s_ahi, 0);
    check("t2_no_up", n_up - s_up, 0);
    check("t2_no_dn", n_dn - s_dn, 0);
    check("t2_no_err", n_err - s_err, 0);

    // 3. Forward detent with exact pulse timing after the final raw edge.
    snap();
    drive(1'b0, 1'b1, 20);
    drive(1'b1, 1'b1, 20);
    drive(1'b1, 1'b0, 20);
    drive(1'b0, 1'b0, 9);
    check("t3_enc_before_latency", {encA, encB}, 2'b10);
    tick(1);
    check("t3_enc_at_latency", {encA, encB}, 2'b00);
    check("t3_step_not_yet", step_up, 1'b0);
    tick(1);
    check("t3_step_at_11", step_up, 1'b1);
    tick(1);
    check("t3_step_one_cycle", step_up, 1'b0);
    tick(10);
    check("t3_up_count", n_up - s_up, 1);
    check("t3_no_dn", n_dn - s_dn, 0);

    // 4. Reverse detent, then a partial move that returns.
    snap();
    drive(1'b1, 1'b0, 20);
    drive(1'b1, 1'b1, 20);
    drive(1'b0, 1'b1, 20);
    drive(1'b0, 1'b0, 20);
    check("t4_dn_count", n_dn - s_dn, 1);
    check("t4_no_up", n_up - s_up, 0);
    snap();
    drive(1'b0, 1'b1, 20);
    drive(1'b0, 1'b0, 20);
    check("t4_partial_no_up", n_up - s_up, 0);
    check("t4_partial_no_dn", n_dn - s_dn, 0);
    drive(1'b0, 1'b1, 20);
    drive(1'b1, 1'b1, 20);
    drive(1'b1, 1'b0, 20);
    check("t4_sub_zero_after_3", n_up - s_up, 0);
    drive(1'b0, 1'b0, 20);
    check("t4_sub_zero_after_4", n_up - s_up, 1);

    // 5. Both channels rise together: illegal transition.
    snap();
    drive(1'b1, 1'b1, 9);
    check("t5_err_before", err, 1'b0);
    tick(1);
    check("t5_err_at_10", err, 1'b1);
    tick(1);
    check("t5_err_one_cycle", err, 1'b0);
    tick(10);
    check("t5_err_count", n_err - s_err, 1);
    check("t5_no_step", (n_up - s_up) + (n_dn - s_dn), 0);
    drive(1'b1, 1'b0, 20);
    drive(1'b0, 1'b0, 20);
    drive(1'b0, 1'b1, 20);
    check("t5_no_step_after_3", n_up - s_up, 0);
    drive(1'b1, 1'b1, 20);
    check("t5_step_after_4", n_up - s_up, 1);
    drive(1'b0, 1'b0, 20);

    // 6. Mode toggling and en gating (mode was cleared by the earlier reset).
    rawbtn = 1'b1;
    tick(20);
    check("t6_mode_first_press", mode, 1'b1);
    rawbtn = 1'b0;
    tick(20);
    en = 1'b0;
    rawbtn = 1'b1;
    tick(20);
    check("t6_mode_second_press_en0", mode, 1'b0);
    rawbtn = 1'b0;
    tick(20);
    snap();
    drive(1'b0, 1'b1, 20);
    check("t6_debounce_runs_en0", {encA, encB}, 2'b01);
    drive(1'b1, 1'b1, 20);
    drive(1'b1, 1'b0, 20);
    drive(1'b0, 1'b0, 20);
    check("t6_en0_no_up", n_up - s_up, 0);
    check("t6_en0_no_err", n_err - s_err, 0);
    en = 1'b1;
    tick(20);
    check("t6_reenable_quiet", (n_up - s_up) + (n_dn - s_dn) + (n_err - s_err), 0);
    drive(1'b0, 1'b1, 20);
    drive(1'b1, 1'b1, 20);
    drive(1'b1, 1'b0, 20);
    drive(1'b0, 1'b0, 20);
    check("t6_reenable_detent", n_up - s_up, 1);

    check("exclusive_pulses", n_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
